// File: rtl/sudoku_candidate_scanner.sv
// Candidate scanner for one sudoku cell: walks the row, column and box peers one per cycle,
// clearing digits seen, then reports the remaining candidate mask, its popcount and whether
// exactly one digit remains.
module sudoku_candidate_scanner #(
  parameter int unsigned BOX = 3,
  parameter int unsigned VW  = 4,
  parameter int unsigned IW  = 7
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [IW-1:0]                        cell_index,
  input  logic [BOX*BOX*BOX*BOX*VW-1:0]        board_flat,
  output logic                                 busy,
  output logic                                 done,
  output logic [BOX*BOX-1:0]                   cand_mask,
  output logic [$clog2(BOX*BOX+1)-1:0]         cand_count,
  output logic                                 single,
  output logic [VW-1:0]                        single_val,
  output logic                                 cell_filled,
  output logic                                 bad_value,
  output logic                                 range_err
);

  localparam int unsigned N  = BOX * BOX;
  localparam int unsigned NN = N * N;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned XW = IW + 1;

  typedef enum logic [2:0] {StIdle, StRow, StCol, StBoxs, StFin} state_e;

  state_e          state_q;
  logic [XW-1:0]   p_q, row_q, col_q, r0_q, c0_q, tgt_q;
  logic [N-1:0]    mask_q, mask_nxt;
  logic            bad_q, bad_nxt, filled_q;
  logic            busy_q, done_q, range_q;
  logic [N-1:0]    cand_mask_q;
  logic [CW-1:0]   cand_count_q;
  logic            single_q, cell_filled_q;
  logic [VW-1:0]   single_val_q;

  // Start-time decode of the requested cell
  logic [XW-1:0]   idx_x, row_s, col_s, r0_s, c0_s;
  logic            oor;
  logic [VW-1:0]   tgt_val;

  assign idx_x   = XW'(cell_index);
  assign oor     = idx_x >= XW'(NN);
  assign row_s   = idx_x / XW'(N);
  assign col_s   = idx_x % XW'(N);
  assign r0_s    = (row_s / XW'(BOX)) * XW'(BOX);
  assign c0_s    = (col_s / XW'(BOX)) * XW'(BOX);
  // Shifting past the board yields 0, so an out-of-range index reads as empty
  assign tgt_val = VW'(board_flat >> (32'(cell_index) * VW));

  logic [XW-1:0]   peer;
  logic [VW-1:0]   peer_val;
  logic            last_peer;

  assign last_peer = (p_q == XW'(N - 1));

  // Current peer address and the mask/bad update it implies
  always_comb begin
    peer     = '0;
    mask_nxt = mask_q;
    bad_nxt  = bad_q;
    unique case (state_q)
      StRow:   peer = row_q * XW'(N) + p_q;
      StCol:   peer = p_q * XW'(N) + col_q;
      StBoxs:  peer = (r0_q + p_q / XW'(BOX)) * XW'(N) + c0_q + p_q % XW'(BOX);
      default: peer = '0;
    endcase
    peer_val = VW'(board_flat >> (32'(peer) * VW));
    if (peer != tgt_q && peer_val != '0) begin
      if (32'(peer_val) > N) begin
        bad_nxt = 1'b1;
      end else begin
        for (int k = 0; k < int'(N); k++) begin
          if (int'(peer_val) == k + 1) mask_nxt[k] = 1'b0;
        end
      end
    end
  end

  // Popcount and sole-digit lookup of the final mask
  logic [CW-1:0] cnt;
  logic [VW-1:0] sv;

  always_comb begin
    cnt = '0;
    sv  = '0;
    for (int k = 0; k < int'(N); k++) begin
      cnt = cnt + CW'(mask_q[k]);
      if (mask_q[k]) sv = VW'(k + 1);
    end
    if (cnt != CW'(1)) sv = '0;
  end

  // Control FSM with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      p_q           <= '0;
      row_q         <= '0;
      col_q         <= '0;
      r0_q          <= '0;
      c0_q          <= '0;
      tgt_q         <= '0;
      mask_q        <= '0;
      bad_q         <= 1'b0;
      filled_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      range_q       <= 1'b0;
      cand_mask_q   <= '0;
      cand_count_q  <= '0;
      single_q      <= 1'b0;
      single_val_q  <= '0;
      cell_filled_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            range_q <= oor;
            bad_q   <= 1'b0;
            p_q     <= '0;
            if (oor) begin
              // No scan: FIN publishes an all-zero result
              mask_q   <= '0;
              filled_q <= 1'b0;
              state_q  <= StFin;
            end else begin
              row_q    <= row_s;
              col_q    <= col_s;
              r0_q     <= r0_s;
              c0_q     <= c0_s;
              tgt_q    <= idx_x;
              mask_q   <= '1;
              filled_q <= (tgt_val != '0);
              busy_q   <= 1'b1;
              state_q  <= StRow;
            end
          end
        end
        StRow, StCol, StBoxs: begin
          mask_q <= mask_nxt;
          bad_q  <= bad_nxt;
          if (last_peer) begin
            p_q <= '0;
            unique case (state_q)
              StRow:   state_q <= StCol;
              StCol:   state_q <= StBoxs;
              default: begin
                state_q <= StFin;
                busy_q  <= 1'b0;
              end
            endcase
          end else begin
            p_q <= p_q + XW'(1);
          end
        end
        StFin: begin
          cand_mask_q   <= mask_q;
          cand_count_q  <= cnt;
          single_q      <= (cnt == CW'(1));
          single_val_q  <= sv;
          cell_filled_q <= filled_q;
          done_q        <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cand_mask   = cand_mask_q;
  assign cand_count  = cand_count_q;
  assign single      = single_q;
  assign single_val  = single_val_q;
  assign cell_filled = cell_filled_q;
  assign bad_value   = bad_q;
  assign range_err   = range_q;

endmodule

// File: tb/tb_sudoku_candidate_scanner.sv
// Scoreboard bench for sudoku_candidate_scanner: a BOX=3 and a BOX=2 instance, directed
// starts push expected results, per-instance monitors pop and compare on each done pulse.
module tb_sudoku_candidate_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int nbad = 0;

  typedef struct {
    logic [8:0] mask;
    logic [3:0] cnt;
    logic       sgl;
    logic [3:0] sv;
    logic       filled;
    logic       bad;
    logic       rerr;
    int         cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];
  exp_t e3, e2;

  // BOX=3 instance
  logic         s3_start = 1'b0;
  logic [6:0]   s3_idx = '0;
  logic [323:0] s3_board = '0;
  logic         s3_busy, s3_done, s3_single, s3_filled, s3_bad, s3_rerr;
  logic [8:0]   s3_mask;
  logic [3:0]   s3_cnt, s3_sv;

  sudoku_candidate_scanner #(.BOX(3), .VW(4), .IW(7)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .cell_index(s3_idx), .board_flat(s3_board),
    .busy(s3_busy), .done(s3_done), .cand_mask(s3_mask), .cand_count(s3_cnt),
    .single(s3_single), .single_val(s3_sv), .cell_filled(s3_filled), .bad_value(s3_bad),
    .range_err(s3_rerr)
  );

  // BOX=2 instance
  logic        s2_start = 1'b0;
  logic [6:0]  s2_idx = '0;
  logic [63:0] s2_board = '0;
  logic        s2_busy, s2_done, s2_single, s2_filled, s2_bad, s2_rerr;
  logic [3:0]  s2_mask, s2_sv;
  logic [2:0]  s2_cnt;

  sudoku_candidate_scanner #(.BOX(2), .VW(4), .IW(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .cell_index(s2_idx), .board_flat(s2_board),
    .busy(s2_busy), .done(s2_done), .cand_mask(s2_mask), .cand_count(s2_cnt),
    .single(s2_single), .single_val(s2_sv), .cell_filled(s2_filled), .bad_value(s2_bad),
    .range_err(s2_rerr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] mask, input logic [3:0] cnt, input logic sgl,
                              input logic [3:0] sv, input logic filled, input logic bad,
                              input logic rerr);
    exp_t e;
    e.mask = mask; e.cnt = cnt; e.sgl = sgl; e.sv = sv;
    e.filled = filled; e.bad = bad; e.rerr = rerr; e.cyc = 0;
    return e;
  endfunction

  // Monitor: BOX=3 results
  always @(negedge clk) begin
    if (rst_n && s3_done) begin
      if (q3.size() == 0) begin
        total++; nbad++;
        $display("FAIL unexpected_done3: got done=1 at cycle %0d want no done", cyc);
      end else begin
        e3 = q3.pop_front();
        chk("done_cycle3", cyc, e3.cyc);
        chk("mask3", 32'(s3_mask), 32'(e3.mask));
        chk("count3", 32'(s3_cnt), 32'(e3.cnt));
        chk("single3", 32'(s3_single), 32'(e3.sgl));
        chk("single_val3", 32'(s3_sv), 32'(e3.sv));
        chk("filled3", 32'(s3_filled), 32'(e3.filled));
        chk("bad3", 32'(s3_bad), 32'(e3.bad));
        chk("range3", 32'(s3_rerr), 32'(e3.rerr));
        chk("busy_at_done3", 32'(s3_busy), 32'(0));
      end
    end
  end

  // Monitor: BOX=2 results
  always @(negedge clk) begin
    if (rst_n && s2_done) begin
      if (q2.size() == 0) begin
        total++; nbad++;
        $display("FAIL unexpected_done2: got done=1 at cycle %0d want no done", cyc);
      end else begin
        e2 = q2.pop_front();
        chk("done_cycle2", cyc, e2.cyc);
        chk("mask2", 32'(s2_mask), 32'(e2.mask));
        chk("count2", 32'(s2_cnt), 32'(e2.cnt));
        chk("single2", 32'(s2_single), 32'(e2.sgl));
        chk("single_val2", 32'(s2_sv), 32'(e2.sv));
        chk("filled2", 32'(s2_filled), 32'(e2.filled));
        chk("bad2", 32'(s2_bad), 32'(e2.bad));
        chk("range2", 32'(s2_rerr), 32'(e2.rerr));
      end
    end
  end

  task automatic set3(input int k, input logic [3:0] v);
    s3_board[k*4 +: 4] = v;
  endtask

  // Called #1 after a rising edge; start is sampled on the next edge
  task automatic go3(input logic [6:0] idx, input exp_t e, input int lat);
    e.cyc = cyc + 1 + lat;
    q3.push_back(e);
    s3_idx = idx;
    s3_start = 1'b1;
    @(posedge clk); #1;
    s3_start = 1'b0;
  endtask

  task automatic go2(input logic [6:0] idx, input exp_t e, input int lat);
    e.cyc = cyc + 1 + lat;
    q2.push_back(e);
    s2_idx = idx;
    s2_start = 1'b1;
    @(posedge clk); #1;
    s2_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q3.size() != 0 || q2.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [3:0] b2 [16];
    b2 = '{4, 2, 3, 1, 3, 1, 4, 2, 2, 4, 1, 3, 1, 3, 2, 0};

    // Reset values while held in reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(s3_busy), 32'(0));
    chk("rst_done", 32'(s3_done), 32'(0));
    chk("rst_mask", 32'(s3_mask), 32'(0));
    chk("rst_count", 32'(s3_cnt), 32'(0));
    chk("rst_single", 32'(s3_single), 32'(0));
    chk("rst_range", 32'(s3_rerr), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty board, centre cell; a start during FIN must be ignored
    go3(7'd40, mk(9'h1FF, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), 28);
    repeat (27) begin @(posedge clk); #1; end
    s3_idx = 7'd0; s3_start = 1'b1;
    @(posedge clk); #1;
    s3_start = 1'b0;
    drain();

    // Row 0 missing only 5; a mid-scan start with another index must be ignored
    for (int k = 0; k < 9; k++) set3(k, (k == 4) ? 4'd0 : 4'(k + 1));
    go3(7'd4, mk(9'h010, 4'd1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0), 28);
    repeat (4) begin @(posedge clk); #1; end
    s3_idx = 7'd0; s3_start = 1'b1;
    @(posedge clk); #1;
    s3_start = 1'b0;
    drain();

    // Column, box and row peers plus an illegal value
    s3_board = '0;
    set3(9, 4'd5); set3(20, 4'd7); set3(8, 4'd3); set3(1, 4'd11);
    go3(7'd0, mk(9'h1AB, 4'd6, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0), 28);
    drain();

    // Same, target itself filled: mask unaffected by its own value
    set3(0, 4'd5);
    go3(7'd0, mk(9'h1AB, 4'd6, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0), 28);
    drain();

    // Out-of-range index, then a legal start clears range_err
    go3(7'd81, mk(9'h000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1), 1);
    drain();
    go3(7'd40, mk(9'h1FF, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0), 28);
    drain();

    // 4x4 board, last cell empty
    for (int k = 0; k < 16; k++) s2_board[k*4 +: 4] = b2[k];
    go2(7'd15, mk(9'h008, 4'd1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0), 13);
    drain();

    // Reset mid-scan: busy drops at once and no done follows
    for (int k = 0; k < 9; k++) set3(k, (k == 4) ? 4'd0 : 4'(k + 1));
    s3_idx = 7'd40; s3_start = 1'b1;
    @(posedge clk); #1;
    s3_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    s3_start = 1'b1;
    @(posedge clk); #1;
    s3_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("busy_before_reset", 32'(s3_busy), 32'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("busy_in_reset", 32'(s3_busy), 32'(0));
    chk("mask_in_reset", 32'(s3_mask), 32'(0));
    chk("count_in_reset", 32'(s3_cnt), 32'(0));
    chk("done_in_reset", 32'(s3_done), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end

    // Restart after reset gives a normal result
    go3(7'd4, mk(9'h010, 4'd1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0), 28);
    drain();

    while (q3.size() != 0) begin
      void'(q3.pop_front());
      total++; nbad++;
      $display("FAIL missing_done3: got no done want done");
    end
    while (q2.size() != 0) begin
      void'(q2.pop_front());
      total++; nbad++;
      $display("FAIL missing_done2: got no done want done");
    end

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
